// File: rtl/fu_rr_arbiter_pkg.sv
// Shared definitions for the round-robin functional-unit arbiter:
// FSM state encoding and a width helper used by the interface and RTL.
package fu_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Ceiling log2, never smaller than 1 so a single client still gets a 1-bit id.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fu_rr_arbiter_if.sv
// Bundle of the client-side and FU-side handshake signals of the arbiter.
// master = the arbiter itself, slave = the clients plus the functional unit.
interface fu_rr_arbiter_if
    import fu_rr_arbiter_pkg::*;
#(
    parameter int num_clients = 4,
    parameter int data_width  = 32,
    parameter int input_size  = 2
);

    localparam int id_width = clog2_min1(num_clients);

    logic [num_clients-1:0]                       cli_req;
    logic [num_clients*input_size*data_width-1:0] cli_din;
    logic [num_clients-1:0]                       cli_ack;
    logic [data_width-1:0]                        cli_dout;
    logic [id_width-1:0]                          cli_id;

    logic [input_size-1:0]                        fu_req_l;
    logic [input_size-1:0]                        fu_ack_l;
    logic [input_size*data_width-1:0]             fu_din;
    logic                                         fu_req_r;
    logic                                         fu_ack_r;
    logic [data_width-1:0]                        fu_dout;

    logic                                         busy;
    logic [31:0]                                  job_count;

    modport master (
        input  cli_req, cli_din, fu_req_l, fu_ack_r, fu_dout,
        output cli_ack, cli_dout, cli_id, fu_ack_l, fu_din, fu_req_r, busy, job_count
    );

    modport slave (
        output cli_req, cli_din, fu_req_l, fu_ack_r, fu_dout,
        input  cli_ack, cli_dout, cli_id, fu_ack_l, fu_din, fu_req_r, busy, job_count
    );

endinterface

// File: rtl/fu_rr_arbiter_rr_pick.sv
// Rotate-priority selector: returns the first requesting client at or after
// the round-robin pointer, wrapping around the client range.
module fu_rr_arbiter_rr_pick
    import fu_rr_arbiter_pkg::*;
#(
    parameter int num_clients = 4,
    parameter int id_width    = clog2_min1(num_clients)
) (
    input  logic [num_clients-1:0] req,
    input  logic [id_width-1:0]    ptr,
    output logic                   valid,
    output logic [id_width-1:0]    idx
);

    // Scan from the farthest offset down so the closest requester wins last.
    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = num_clients - 1; off >= 0; off--) begin
            cand = (int'(ptr) + off) % num_clients;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = id_width'(cand);
            end
        end
    end

endmodule

// File: rtl/fu_rr_arbiter.sv
// Round-robin arbiter time-multiplexing one req/ack functional unit among
// several clients. Operands of the granted client are latched, handed to the
// FU one input at a time, and the FU result is returned with a one-cycle ack.
module fu_rr_arbiter
    import fu_rr_arbiter_pkg::*;
#(
    parameter int num_clients = 4,
    parameter int data_width  = 32,
    parameter int input_size  = 2
) (
    input logic             clk,
    input logic             rst_n,
    fu_rr_arbiter_if.master bus
);

    localparam int id_width  = clog2_min1(num_clients);
    localparam int job_width = input_size * data_width;

    state_t state, next_state;

    logic [id_width-1:0]    rr_ptr, rr_ptr_d;
    logic [id_width-1:0]    next_ptr;
    logic [id_width-1:0]    pick_idx;
    logic                   pick_valid;
    logic [input_size-1:0]  sent, sent_d;
    logic [input_size-1:0]  issue_now;
    logic                   all_sent;

    logic [num_clients-1:0] cli_ack_q, cli_ack_d;
    logic [data_width-1:0]  cli_dout_q, cli_dout_d;
    logic [id_width-1:0]    cli_id_q, cli_id_d;
    logic [input_size-1:0]  fu_ack_l_q, fu_ack_l_d;
    logic [job_width-1:0]   fu_din_q, fu_din_d;
    logic                   fu_req_r_q, fu_req_r_d;
    logic                   busy_q, busy_d;
    logic [31:0]            job_count_q, job_count_d;

    fu_rr_arbiter_rr_pick #(
        .num_clients (num_clients),
        .id_width    (id_width)
    ) u_pick (
        .req   (bus.cli_req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // An operand is offered only when the FU asks, it has not gone yet, and
    // the previous pulse on that input has ended (no back-to-back acks).
    assign issue_now = bus.fu_req_l & ~sent & ~fu_ack_l_q;
    assign all_sent  = &sent && !(|fu_ack_l_q);

    // Pointer advances one past the client just served, wrapping at the top.
    always_comb begin
        next_ptr = '0;
        if (int'(cli_id_q) < num_clients - 1) begin
            next_ptr = cli_id_q + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid)   next_state = ISSUE;
            ISSUE:   if (all_sent)     next_state = COLLECT;
            COLLECT: if (bus.fu_ack_r) next_state = RESP;
            RESP:                      next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    // Next values of every registered output and of the datapath registers.
    always_comb begin
        rr_ptr_d    = rr_ptr;
        sent_d      = sent;
        cli_ack_d   = '0;
        cli_dout_d  = cli_dout_q;
        cli_id_d    = cli_id_q;
        fu_ack_l_d  = '0;
        fu_din_d    = fu_din_q;
        fu_req_r_d  = fu_req_r_q;
        job_count_d = job_count_q;
        busy_d      = (next_state != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    fu_din_d = bus.cli_din[int'(pick_idx)*job_width +: job_width];
                    cli_id_d = pick_idx;
                    sent_d   = '0;
                end
            end
            ISSUE: begin
                fu_ack_l_d = issue_now;
                sent_d     = sent | issue_now;
                if (all_sent) begin
                    fu_req_r_d = 1'b1;
                end
            end
            COLLECT: begin
                if (bus.fu_ack_r) begin
                    cli_dout_d          = bus.fu_dout;
                    fu_req_r_d          = 1'b0;
                    cli_ack_d[cli_id_q] = 1'b1;
                    job_count_d         = job_count_q + 32'd1;
                end
            end
            RESP: begin
                rr_ptr_d = next_ptr;
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            sent        <= '0;
            cli_ack_q   <= '0;
            cli_dout_q  <= '0;
            cli_id_q    <= '0;
            fu_ack_l_q  <= '0;
            fu_din_q    <= '0;
            fu_req_r_q  <= 1'b0;
            busy_q      <= 1'b0;
            job_count_q <= '0;
        end else begin
            rr_ptr      <= rr_ptr_d;
            sent        <= sent_d;
            cli_ack_q   <= cli_ack_d;
            cli_dout_q  <= cli_dout_d;
            cli_id_q    <= cli_id_d;
            fu_ack_l_q  <= fu_ack_l_d;
            fu_din_q    <= fu_din_d;
            fu_req_r_q  <= fu_req_r_d;
            busy_q      <= busy_d;
            job_count_q <= job_count_d;
        end
    end

    assign bus.cli_ack   = cli_ack_q;
    assign bus.cli_dout  = cli_dout_q;
    assign bus.cli_id    = cli_id_q;
    assign bus.fu_ack_l  = fu_ack_l_q;
    assign bus.fu_din    = fu_din_q;
    assign bus.fu_req_r  = fu_req_r_q;
    assign bus.busy      = busy_q;
    assign bus.job_count = job_count_q;

endmodule

// File: doc/fu_rr_arbiter.md
# fu_rr_arbiter

Round-robin arbiter that shares one `async_operator` functional unit (FU) among `num_clients` requesters using the codebase req/ack handshake. Each client presents a complete operand set and waits for a one-cycle ack carrying the result. The arbiter acts as the producer on the FU's left (operand) side and as the consumer on its right (result) side. It sits inside an `arf`-level dataflow graph wherever a costly operator (`mul`, `add`) is time-multiplexed instead of replicated.

## Interface
- `num_clients`, 4: number of requesting channels, ≥1
- `data_width`, 32: operand/result width
- `input_size`, 2: FU operand count (1..3), must match the FU instance
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `cli_req` in `num_clients`: client i has a job pending; level, held until its ack
- `cli_din` in `num_clients*input_size*data_width`: client i operands, slice i, stable while `cli_req[i]`
- `cli_ack` out `num_clients`: one-cycle pulse; result valid on `cli_dout`
- `cli_dout` out `data_width`: result of the last completed job
- `cli_id` out `$clog2(num_clients)` (min 1): index of the granted client
- `fu_req_l` in `input_size`: FU requests operand k
- `fu_ack_l` out `input_size`: operand-delivered pulse per input
- `fu_din` out `input_size*data_width`: operands to the FU
- `fu_req_r` out 1: arbiter requests the FU result
- `fu_ack_r` in 1: FU result valid on `fu_dout`
- `fu_dout` in `data_width`: FU result
- `busy` out 1: a job is in flight (state ≠ IDLE)
- `job_count` out 32: completed jobs, wraps modulo 2^32

## Operation
- FSM states are IDLE, ISSUE, COLLECT and RESP. All outputs are registered.
- **IDLE:** if any `cli_req` bit is set, pick g = first requesting index at or after `rr_ptr`, searching cyclically.
  - Latch `cli_din` slice g into `fu_din`.
  - Set `cli_id <= g` and clear `sent`.
  - Move to ISSUE.
- **ISSUE:** for each k, if `fu_req_l[k] & ~sent[k] & ~fu_ack_l[k]`, pulse `fu_ack_l[k]` for one cycle and set `sent[k]`.
  - `fu_din` never changes in ISSUE. It was loaded at least one cycle before any `fu_ack_l` edge, because the FU samples on `posedge ack_l`.
  - When all `sent` bits are set and no `fu_ack_l` is high, set `fu_req_r <= 1` and move to COLLECT.
- **COLLECT:** hold `fu_req_r`. On `fu_ack_r`, capture `fu_dout` into `cli_dout`, drop `fu_req_r` and move to RESP.
- **RESP:**
  - Pulse `cli_ack[g]` for one cycle.
  - Set `rr_ptr <= (g+1) mod num_clients`.
  - Increment `job_count`.
  - Return to IDLE.
- **Reset:** an asynchronous reset at any point, including mid-job, forces IDLE and clears every output and internal register to 0 (`rr_ptr = 0`, `sent = 0`). The FU must share `rst_n` so that any partially captured operands are discarded.
- **Fairness:** a client that re-asserts `cli_req` immediately after its ack is served only after every other requester in rotation.
- **Single requester:** served back-to-back.
- **Data path:** widths pass through unchanged. No arithmetic is performed in the arbiter except `rr_ptr` and `job_count` increments.

## Timing
- Reset values: `cli_ack = 0`, `cli_dout = 0`, `cli_id = 0`, `fu_ack_l = 0`, `fu_din = 0`, `fu_req_r = 0`, `busy = 0`, `job_count = 0`.
- `cli_req` seen in IDLE at edge t gives `busy = 1` and `fu_din` loaded at t+1.
- The earliest `fu_ack_l` pulse is at t+2, provided `fu_req_l` is already high.
- COLLECT waits indefinitely for `fu_ack_r`. There is no timeout.
- `cli_ack` rises one cycle after `fu_ack_r` is sampled. `cli_dout` is valid in that same cycle and holds until the next RESP.
- Minimum job period against an `add` FU with its requests pending: 6 cycles.
- `fu_ack_l[k]` is never high two consecutive cycles. At most one `cli_ack` bit is high in any cycle.
- A `fu_ack_r` outside COLLECT is ignored. A `cli_req` drop mid-job does not abort the job; its ack is still issued.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE=0, ISSUE=1, COLLECT=2, RESP=3)
  - a `clog2` helper clamped to a minimum of 1
- Sub-module `rr_pick`: combinational rotate-priority selector. Inputs are the `cli_req` vector and `rr_ptr`. Outputs are a valid flag and index g.
- Top-level holds the FSM, the operand/result registers and the counter.

## Test plan
- Bench setup: `num_clients=4`, `input_size=2`, FU = `async_operator` `add`.
- **Single job:** client 2 only, operands 5 and 7 → one `cli_ack[2]` pulse, `cli_dout=12`, `cli_id=2`, `job_count=1`, and no other ack bit ever high.
- **Full contention:** all four clients request continuously with operands (i,i) → grant order 0,1,2,3,0,1…; `cli_dout` = 0,2,4,6,0…; `job_count=8` after 8 acks.
- **Stalled operand:** hold `fu_req_l[1]` low for 10 cycles → only `fu_ack_l[0]` pulses; FSM stays in ISSUE with `busy=1`; completes normally once `fu_req_l[1]` rises.
- **Reset mid-job:** assert `rst_n=0` in COLLECT → all outputs are 0 immediately (asynchronously); after release, client 3's pending request is served first (with `rr_ptr=0` and only client 3 requesting); no stale ack appears.
- **Pointer wrap:** clients 3 and 0 request alternately → `rr_ptr` wraps 3→0; order is strictly 3,0,3,0; `job_count` increments by exactly 1 per ack.
- **Long run:** random `cli_req` drops per client over 5000 jobs → every ack matches a scoreboard sum and no client waits more than 3 other jobs.
